rr_2_to_1_mux_arbiter: RTL and testbench
========================================

// Module: rr_2_to_1_mux_arbiter
// PURPOSE
//  Shares one 2-to-1 mux datapath between two valid/ready requesters.
//  - Round-robin grant selects which input the mux forwards.
//  - A one-entry registered output stage gives 1-cycle latency at full throughput.
//  - Saturating per-requester beat counters support bring-up and debug.
// PARAMETERS
//  DATA_WIDTH  8   width of in0_data, in1_data, out_data
//  CNT_WIDTH   16  width of the per-requester beat counters
// PORTS
//  clk        in   1           single clock, all state on rising edge
//  rst        in   1           synchronous, active-high reset
//  in0_valid  in   1           requester 0 has a beat
//  in0_data   in   DATA_WIDTH  requester 0 beat
//  in0_ready  out  1           requester 0 beat accepted this cycle (valid&ready)
//  in1_valid  in   1           requester 1 has a beat
//  in1_data   in   DATA_WIDTH  requester 1 beat
//  in1_ready  out  1           requester 1 beat accepted this cycle
//  out_valid  out  1           registered output beat present
//  out_data   out  DATA_WIDTH  registered mux output
//  out_sel    out  1           source of current out_data (0=in0, 1=in1)
//  out_ready  in   1           downstream accepts out beat
//  cnt0       out  CNT_WIDTH   beats accepted from in0, saturating
//  cnt1       out  CNT_WIDTH   beats accepted from in1, saturating
//  in0_last   in   1           [ARB_LOCK_EN only] last beat of in0 packet
//  in1_last   in   1           [ARB_LOCK_EN only] last beat of in1 packet
// BEHAVIOUR
//  Reset values (rst=1 at a clock edge):
//  - out_valid=0, out_data=0, out_sel=0, cnt0=cnt1=0, last_grant=1, state=IDLE.
//  - in0_ready and in1_ready are forced to 0 combinationally while rst=1.
//  Load enable (combinational): load = ~out_valid | out_ready.
//  Grant g (combinational):
//  - Exactly one input valid: g = that input.
//  - Both valid: g = ~last_grant, so in0 wins the first contention after reset.
//  - Neither valid: no grant; both ready outputs are 0.
//  Ready: inN_ready = load & inN_valid & (g==N) & ~rst. At most one ready is high.
//  Transfer on input g (valid&ready):
//  - Registers out_data<=in_g_data, out_valid<=1, out_sel<=g, last_grant<=g.
//  - cnt_g increments by 1; it holds at 2^CNT_WIDTH-1 (no wrap).
//  No transfer: out_ready=1 sets out_valid<=0. Otherwise out_data, out_valid, out_sel hold.
//  Simultaneous drain and load: the new beat replaces the old one in the same cycle; no bubble.
//  Latency: input accepted at edge N is visible on out_* after edge N.
//  Backpressure: out_valid=1 & out_ready=0 -> both ready outputs 0; out_data stable.
//  Reset mid-operation: an in-flight beat in the output stage is dropped (out_valid=0).
//  Counters and lock state are cleared.
// CONFIGURATION
//  ARB_LOCK_EN defined:
//  - Adds ports in0_last and in1_last and an FSM with states IDLE, LOCK0, LOCK1.
//  - IDLE: grant follows the rules above. A transfer from g with in_g_last=0 -> LOCKg.
//    A transfer with in_g_last=1 stays in IDLE.
//  - LOCKg: g is forced. The other input is never readied, even if g is not valid.
//    A transfer from g with in_g_last=1 -> IDLE.
//  - last_grant updates on every transfer, so the other input wins after the packet ends.
//  ARB_LOCK_EN undefined:
//  - No last ports and no FSM; arbitration is per beat.
// TESTING
//  1. Reset: after rst=1 for 2 cycles -> out_valid=0, out_data=0, cnt0=cnt1=0.
//     in0_ready=in1_ready=0 during reset.
//  2. Single requester: in0 sends 8'hA5, then 8'h3C, with out_ready=1.
//     -> out_data=A5 then 3C, each 1 cycle after accept; out_sel=0; cnt0=2.
//  3. Contention: both valid continuously, in0=8'h11, in1=8'h22, out_ready=1.
//     -> grants alternate 0,1,0,1; out_data 11,22,11,22; no idle cycles.
//  4. Backpressure: out_valid=1 with data 8'h55, out_ready=0 for 3 cycles.
//     -> out_data stays 55; both readies 0; cnt unchanged.
//     Release -> next beat 1 cycle later.
//  5. Saturation: CNT_WIDTH=2, in1 sends 5 beats -> cnt1 ends at 3.
//  6. ARB_LOCK_EN: in0 sends a 3-beat packet (last on beat 3) while in1 is valid.
//     -> in1_ready=0 until in0 beat 3 is accepted, then in1 is granted next.
//     Also assert rst mid-packet -> state IDLE, out_valid=0.

Source files
------------

// File: rtl/rr_2_to_1_mux_arbiter.sv
// Round-robin 2:1 valid/ready arbiter feeding one registered output stage, with saturating per-input beat counters.
// Define ARB_LOCK_EN to add in0_last/in1_last and hold the grant for a whole packet.
//
// state | meaning (ARB_LOCK_EN only)
// IDLE  | per-beat round-robin arbitration
// LOCK0 | in0 packet in progress, grant held on in0
// LOCK1 | in1 packet in progress, grant held on in1

module rr_2_to_1_mux_arbiter #(
    parameter int DATA_WIDTH = 8,
    parameter int CNT_WIDTH  = 16
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  in0_valid,
    input  logic [DATA_WIDTH-1:0] in0_data,
    output logic                  in0_ready,
    input  logic                  in1_valid,
    input  logic [DATA_WIDTH-1:0] in1_data,
    output logic                  in1_ready,
    output logic                  out_valid,
    output logic [DATA_WIDTH-1:0] out_data,
    output logic                  out_sel,
    input  logic                  out_ready,
    output logic [CNT_WIDTH-1:0]  cnt0,
    output logic [CNT_WIDTH-1:0]  cnt1
`ifdef ARB_LOCK_EN
    ,
    input  logic                  in0_last,
    input  logic                  in1_last
`endif
);

    logic load;
    logic req;
    logic grant;
    logic xfer;
    logic last_grant;

`ifdef ARB_LOCK_EN
    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        LOCK0 = 2'd1,
        LOCK1 = 2'd2
    } state_t;

    state_t state;
    state_t state_next;
    logic   grant_last;
`endif

    always_comb begin
        load  = ~out_valid | out_ready;
        req   = in0_valid | in1_valid;
        // On contention the side that did not win last time gets the beat.
        grant = (in0_valid & in1_valid) ? ~last_grant : in1_valid;
`ifdef ARB_LOCK_EN
        if (state == LOCK0) begin
            grant = 1'b0;
            req   = in0_valid;
        end else if (state == LOCK1) begin
            grant = 1'b1;
            req   = in1_valid;
        end
`endif
        in0_ready = load & req & in0_valid & ~grant & ~rst;
        in1_ready = load & req & in1_valid &  grant & ~rst;
        xfer      = in0_ready | in1_ready;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            out_valid  <= 1'b0;
            out_data   <= '0;
            out_sel    <= 1'b0;
            last_grant <= 1'b1;
        end else if (xfer) begin
            out_valid  <= 1'b1;
            out_data   <= grant ? in1_data : in0_data;
            out_sel    <= grant;
            last_grant <= grant;
        end else if (out_ready) begin
            out_valid  <= 1'b0;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            cnt0 <= '0;
            cnt1 <= '0;
        end else begin
            if (in0_ready && (cnt0 != {CNT_WIDTH{1'b1}}))
                cnt0 <= cnt0 + 1'b1;
            if (in1_ready && (cnt1 != {CNT_WIDTH{1'b1}}))
                cnt1 <= cnt1 + 1'b1;
        end
    end

`ifdef ARB_LOCK_EN
    always_ff @(posedge clk) begin
        if (rst)
            state <= IDLE;
        else
            state <= state_next;
    end

    // A beat without last opens (or continues) a packet on the granted side.
    always_comb begin
        state_next = state;
        grant_last = grant ? in1_last : in0_last;
        if (xfer)
            state_next = grant_last ? IDLE : (grant ? LOCK1 : LOCK0);
    end
`endif

endmodule

// File: tb/tb_rr_2_to_1_mux_arbiter.sv
// Randomized and directed bench for rr_2_to_1_mux_arbiter against a cycle-level behavioural model.
// Two instances share stimulus: CNT_WIDTH=16 and CNT_WIDTH=2 (saturation).

module tb_rr_2_to_1_mux_arbiter;

`ifdef ARB_LOCK_EN
    localparam bit LOCK_EN = 1'b1;
`else
    localparam bit LOCK_EN = 1'b0;
`endif

    logic       clk = 1'b0;
    logic       rst, v0, v1, ordy, l0, l1;
    logic [7:0] d0, d1;

    logic        r0, r1, ov, osel;
    logic [7:0]  od;
    logic [15:0] c0, c1;
    logic        s_r0, s_r1, s_ov, s_sel;
    logic [7:0]  s_od;
    logic [1:0]  s_c0, s_c1;

    int n_checks = 0;
    int n_errors = 0;

    bit         m_valid, m_sel, m_lg;
    logic [7:0] m_data;
    int         m_lock, m_c0, m_c1, m_s0, m_s1;

    always #5 clk = ~clk;

    rr_2_to_1_mux_arbiter #(.DATA_WIDTH(8), .CNT_WIDTH(16)) dut (
        .clk(clk), .rst(rst),
        .in0_valid(v0), .in0_data(d0), .in0_ready(r0),
        .in1_valid(v1), .in1_data(d1), .in1_ready(r1),
        .out_valid(ov), .out_data(od), .out_sel(osel), .out_ready(ordy),
        .cnt0(c0), .cnt1(c1)
`ifdef ARB_LOCK_EN
        , .in0_last(l0), .in1_last(l1)
`endif
    );

    rr_2_to_1_mux_arbiter #(.DATA_WIDTH(8), .CNT_WIDTH(2)) dut_sat (
        .clk(clk), .rst(rst),
        .in0_valid(v0), .in0_data(d0), .in0_ready(s_r0),
        .in1_valid(v1), .in1_data(d1), .in1_ready(s_r1),
        .out_valid(s_ov), .out_data(s_od), .out_sel(s_sel), .out_ready(ordy),
        .cnt0(s_c0), .cnt1(s_c1)
`ifdef ARB_LOCK_EN
        , .in0_last(l0), .in1_last(l1)
`endif
    );

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        if (obs !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0h expected %0h at %0t", tag, obs, exp, $time);
        end
    endtask

    function automatic int sat_inc(input int v, input int max);
        return (v >= max) ? max : v + 1;
    endfunction

    task automatic model_reset();
        m_valid = 0; m_data = 8'h00; m_sel = 0; m_lg = 1; m_lock = -1;
        m_c0 = 0; m_c1 = 0; m_s0 = 0; m_s1 = 0;
    endtask

    // One cycle: drive inputs, compare DUTs to the model, clock, advance the model.
    task automatic step(input bit r, input bit a0, input logic [7:0] x0,
                        input bit a1, input logic [7:0] x1,
                        input bit e0, input bit e1, input bit o);
        bit have, g, load, er0, er1, lastf;
        rst = r; v0 = a0; d0 = x0; v1 = a1; d1 = x1; l0 = e0; l1 = e1; ordy = o;
        #1;
        if (m_lock >= 0) begin
            g    = (m_lock == 1);
            have = g ? a1 : a0;
        end else begin
            have = a0 | a1;
            g    = (a0 && a1) ? !m_lg : a1;
        end
        load = !m_valid || o;
        er0  = !r && load && have && !g;
        er1  = !r && load && have && g;
        chk("in0_ready", r0, er0);
        chk("in1_ready", r1, er1);
        chk("out_valid", ov, m_valid);
        chk("out_data", od, m_data);
        chk("out_sel", osel, m_sel);
        chk("cnt0", c0, m_c0);
        chk("cnt1", c1, m_c1);
        chk("sat_in0_ready", s_r0, er0);
        chk("sat_in1_ready", s_r1, er1);
        chk("sat_out_data", s_od, m_data);
        chk("sat_cnt0", s_c0, m_s0);
        chk("sat_cnt1", s_c1, m_s1);
        @(posedge clk);
        if (r) begin
            model_reset();
        end else if (load && have) begin
            m_valid = 1; m_sel = g; m_lg = g;
            m_data  = g ? x1 : x0;
            if (g) begin
                m_c1 = sat_inc(m_c1, 65535); m_s1 = sat_inc(m_s1, 3);
            end else begin
                m_c0 = sat_inc(m_c0, 65535); m_s0 = sat_inc(m_s0, 3);
            end
            lastf  = g ? e1 : e0;
            m_lock = (LOCK_EN && !lastf) ? int'(g) : -1;
        end else if (o) begin
            m_valid = 0;
        end
        @(negedge clk);
    endtask

    initial begin
        bit exp_sel[4];
        logic [7:0] exp_dat[4];
        exp_sel = '{1'b0, 1'b1, 1'b0, 1'b1};
        exp_dat = '{8'h11, 8'h22, 8'h11, 8'h22};

        rst = 1; v0 = 0; v1 = 0; d0 = 0; d1 = 0; l0 = 1; l1 = 1; ordy = 1;
        repeat (2) @(posedge clk);
        model_reset();
        @(negedge clk);

        // Reset held two cycles while both requesters are valid.
        step(1, 1, 8'h01, 1, 8'h02, 1, 1, 1);
        step(1, 1, 8'h01, 1, 8'h02, 1, 1, 1);
        chk("rst_out_valid", ov, 0);
        chk("rst_out_data", od, 0);
        chk("rst_cnt0", c0, 0);

        // Single requester.
        step(0, 1, 8'hA5, 0, 8'h00, 1, 1, 1);
        chk("single_a5", od, 8'hA5);
        step(0, 1, 8'h3C, 0, 8'h00, 1, 1, 1);
        chk("single_3c", od, 8'h3C);
        chk("single_sel", osel, 0);
        chk("single_cnt0", c0, 2);
        step(0, 0, 8'h00, 0, 8'h00, 1, 1, 1);

        // Contention alternates starting with in0.
        step(1, 0, 8'h00, 0, 8'h00, 1, 1, 1);
        for (int i = 0; i < 4; i++) begin
            step(0, 1, 8'h11, 1, 8'h22, 1, 1, 1);
            chk("cont_sel", osel, exp_sel[i]);
            chk("cont_data", od, exp_dat[i]);
            chk("cont_valid", ov, 1);
        end

        // Backpressure.
        step(1, 0, 8'h00, 0, 8'h00, 1, 1, 1);
        step(0, 1, 8'h55, 0, 8'h00, 1, 1, 1);
        for (int i = 0; i < 3; i++) begin
            step(0, 1, 8'h11, 1, 8'h22, 1, 1, 0);
            chk("bp_data", od, 8'h55);
            chk("bp_cnt0", c0, 1);
        end
        step(0, 1, 8'h11, 1, 8'h22, 1, 1, 1);
        chk("bp_release_data", od, 8'h22);
        chk("bp_release_valid", ov, 1);

        // Saturation on the narrow instance.
        step(1, 0, 8'h00, 0, 8'h00, 1, 1, 1);
        for (int i = 0; i < 5; i++)
            step(0, 0, 8'h00, 1, 8'(i + 1), 1, 1, 1);
        chk("sat_cnt1_final", s_c1, 3);
        chk("wide_cnt1_final", c1, 5);

`ifdef ARB_LOCK_EN
        // Packet lock: in1 waits for in0's last beat, then wins.
        step(1, 0, 8'h00, 0, 8'h00, 1, 1, 1);
        step(0, 1, 8'hA0, 1, 8'hB0, 0, 1, 1);
        step(0, 1, 8'hA1, 1, 8'hB0, 0, 1, 1);
        chk("lock_beat2_sel", osel, 0);
        step(0, 1, 8'hA2, 1, 8'hB0, 1, 1, 1);
        chk("lock_beat3_data", od, 8'hA2);
        step(0, 1, 8'hA3, 1, 8'hB0, 1, 1, 1);
        chk("lock_after_sel", osel, 1);
        // Lock holds even when in0 idles, then reset mid-packet clears it.
        step(1, 0, 8'h00, 0, 8'h00, 1, 1, 1);
        step(0, 1, 8'hC0, 0, 8'h00, 0, 1, 1);
        step(0, 0, 8'h00, 1, 8'hD0, 1, 1, 1);
        chk("lock_hold_valid", ov, 0);
        step(1, 0, 8'h00, 0, 8'h00, 1, 1, 1);
        chk("lock_rst_valid", ov, 0);
        step(0, 0, 8'h00, 1, 8'hD1, 1, 1, 1);
        chk("lock_rst_sel", osel, 1);
`endif

        // Randomized traffic with occasional resets.
        for (int i = 0; i < 800; i++) begin
            step(($urandom_range(0, 49) == 0),
                 1'($urandom), 8'($urandom),
                 1'($urandom), 8'($urandom),
                 ($urandom_range(0, 2) == 0), ($urandom_range(0, 2) == 0),
                 ($urandom_range(0, 3) != 0));
        end

        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end

endmodule
